// File: rtl/flasher_pkg.sv
// Shared types, defaults and the state-to-direction helper for the bound-flasher controller.
package flasher_pkg;

  // Counter command; the encodings are fixed by the counter this block drives.
  typedef enum logic [1:0] {
    DECREASE = 2'b00,
    INCREASE = 2'b01,
    PASS     = 2'b11
  } led_bhv_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StUpLo    = 3'd1,
    StDnZero  = 3'd2,
    StUpHi    = 3'd3,
    StDnLo    = 3'd4,
    StUpTop   = 3'd5,
    StDownEnd = 3'd6
  } flasher_state_t;

  localparam int unsigned LedNumberDefault = 16;
  localparam int unsigned KickLoDefault    = 6;
  localparam int unsigned KickHiDefault    = 11;

  // Direction the counter must move while the FSM sits in state s.
  function automatic led_bhv_t state_dir(flasher_state_t s);
    led_bhv_t dir;
    case (s)
      StUpLo, StUpHi, StUpTop:      dir = INCREASE;
      StDnZero, StDnLo, StDownEnd:  dir = DECREASE;
      default:                      dir = PASS;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/flasher_ctrl_if.sv
// Signals between the flasher controller, the LED counter and the board lamps.
interface flasher_ctrl_if
  import flasher_pkg::*;
#(
  parameter int unsigned LED_NUMBER = LedNumberDefault
);
  localparam int unsigned CntW = $clog2(LED_NUMBER) + 1;

  logic                  flick;
  logic [CntW-1:0]       count;
  led_bhv_t              led_bhv;
  logic [LED_NUMBER-1:0] lamp;
  logic                  done;

  // master: the controller. slave: counter/user side.
  modport master (input flick, input count, output led_bhv, output lamp, output done);
  modport slave  (output flick, output count, input led_bhv, input lamp, input done);
endinterface

// File: rtl/flasher_ctrl_lamp_therm_dec.sv
// Count to thermometer-code lamp decoder: lamp_o[i] is lit while count_i > i.
module lamp_therm_dec #(
  parameter int unsigned LED_NUMBER = 16,
  localparam int unsigned CntW = $clog2(LED_NUMBER) + 1
) (
  input  logic [CntW-1:0]       count_i,
  output logic [LED_NUMBER-1:0] lamp_o
);

  // One comparator per lamp.
  always_comb begin
    lamp_o = '0;
    for (int unsigned i = 0; i < LED_NUMBER; i++) begin
      lamp_o[i] = (32'(count_i) > i);
    end
  end

endmodule

// File: rtl/flasher_ctrl.sv
// Bound-flasher sequence controller: walks 0->6->0->11->6->16->0 with flick kickbacks,
// commanding the shared LED counter and decoding its count onto the lamp bar.
module flasher_ctrl
  import flasher_pkg::*;
#(
  parameter int unsigned LED_NUMBER = LedNumberDefault,
  parameter int unsigned KICK_LO    = KickLoDefault,
  parameter int unsigned KICK_HI    = KickHiDefault
) (
  input logic            div_clk,
  input logic            rst,
  flasher_ctrl_if.master bus
);

  localparam int unsigned LED_NUMBER_W = $clog2(LED_NUMBER);
  localparam int unsigned CntW         = LED_NUMBER_W + 1;

  localparam logic [CntW-1:0] KickLoC = CntW'(KICK_LO);
  localparam logic [CntW-1:0] KickHiC = CntW'(KICK_HI);
  localparam logic [CntW-1:0] TopC    = CntW'(LED_NUMBER);

  flasher_state_t state_q, state_d;
  logic           done_q, done_d;
  logic [CntW-1:0] cnt;

  assign cnt = bus.count;

  // State and done pulse registers.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next state; led_bhv follows the next state so each peak/valley lasts one cycle.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    bus.led_bhv = PASS;
    case (state_q)
      StIdle: begin
        if (bus.flick) state_d = StUpLo;
      end
      StUpLo: begin
        if (cnt >= KickLoC) state_d = StDnZero;
      end
      StDnZero: begin
        if (cnt == '0) state_d = StUpHi;
      end
      StUpHi: begin
        if (bus.flick && (cnt == KickLoC || cnt >= KickHiC)) state_d = StDnZero;
        else if (cnt >= KickHiC)                             state_d = StDnLo;
      end
      StDnLo: begin
        if (cnt <= KickLoC) state_d = StUpTop;
      end
      StUpTop: begin
        if (bus.flick && (cnt == KickHiC || cnt >= TopC)) state_d = StDnLo;
        else if (cnt >= TopC)                             state_d = StDownEnd;
      end
      StDownEnd: begin
        if (cnt == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    bus.led_bhv = rst ? PASS : state_dir(state_d);
  end

  assign bus.done = done_q;

  lamp_therm_dec #(
    .LED_NUMBER(LED_NUMBER)
  ) u_lamp_dec (
    .count_i(cnt),
    .lamp_o (bus.lamp)
  );

endmodule

// File: tb/tb_flasher_ctrl.sv
// Closed-loop bench: flasher_ctrl driving a behavioural up/down LED counter.
module tb_flasher_ctrl;
  import flasher_pkg::*;

  logic div_clk = 1'b0;
  logic rst     = 1'b1;

  flasher_ctrl_if #(.LED_NUMBER(16)) bus ();

  flasher_ctrl #(
    .LED_NUMBER(16),
    .KICK_LO   (6),
    .KICK_HI   (11)
  ) dut (
    .div_clk(div_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 div_clk = ~div_clk;

  // The LED counter the controller closes the loop with.
  always @(posedge div_clk) begin
    if (rst) bus.count <= '0;
    else if (bus.led_bhv == INCREASE) bus.count <= bus.count + 5'd1;
    else if (bus.led_bhv == DECREASE) bus.count <= bus.count - 5'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase index over the target list, plus kickback rules.
  // Phase 0 is idle; odd phases climb to their target, even phases fall to it.
  int tgt [7] = '{0, 6, 0, 11, 6, 16, 0};
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;

  initial begin
    int c, np, exp_bhv, exp_lamp;
    bit f, reached, nd;
    forever begin
      @(negedge div_clk);
      np = m_phase;
      nd = 1'b0;
      exp_bhv = int'(PASS);
      if (cmp_en) begin
        c = int'(bus.count);
        f = bus.flick;
        if (m_phase == 0) begin
          np = f ? 1 : 0;
        end else begin
          reached = (m_phase % 2 == 1) ? (c >= tgt[m_phase]) : (c <= tgt[m_phase]);
          if (m_phase == 3 && f && (c == 6 || c >= 11))       np = 2;
          else if (m_phase == 5 && f && (c == 11 || c >= 16)) np = 4;
          else if (reached)                                   np = (m_phase == 6) ? 0 : m_phase + 1;
        end
        nd = (m_phase == 6 && np == 0);
        if (!rst && np != 0) exp_bhv = (np % 2 == 1) ? int'(INCREASE) : int'(DECREASE);
        exp_lamp = 0;
        for (int i = 0; i < 16; i++) if (c > i) exp_lamp |= (1 << i);
        chk("led_bhv", int'(bus.led_bhv), exp_bhv);
        chk("done", int'(bus.done), int'(m_done));
        chk("count", c, m_cnt);
        chk("lamp", int'(bus.lamp), exp_lamp);
        if (bus.done) done_seen++;
      end
      @(posedge div_clk);
      if (cmp_en) begin
        if (rst) begin
          m_phase = 0; m_done = 1'b0; m_cnt = 0;
        end else begin
          m_phase = np; m_done = nd;
          if (exp_bhv == int'(INCREASE)) m_cnt++;
          else if (exp_bhv == int'(DECREASE)) m_cnt--;
        end
      end
    end
  end

  task automatic step();
    @(posedge div_clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    for (int k = 0; k < 300 && int'(bus.count) != v; k++) step();
    chk($sformatf("reach_%0d", v), int'(bus.count), v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic flick_pulse();
    bus.flick = 1'b1;
    step();
    bus.flick = 1'b0;
  endtask

  initial begin
    #250000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx;
    bus.flick = 1'b0;
    rst = 1'b1;
    step();
    cmp_en = 1'b1;
    // Reset state and idle with no flick.
    chk("rst_bhv", int'(bus.led_bhv), int'(PASS));
    chk("rst_lamp", int'(bus.lamp), 0);
    chk("rst_done", int'(bus.done), 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("idle_count", int'(bus.count), 0);
    chk("idle_bhv", int'(bus.led_bhv), int'(PASS));

    // Full pattern from one flick.
    done_seen = 0;
    flick_pulse();
    wait_cnt(6);
    chk("peak6_lamp", int'(bus.lamp), 'h003F);
    chk("peak6_bhv", int'(bus.led_bhv), int'(DECREASE));
    step();
    chk("after_peak6", int'(bus.count), 5);
    wait_cnt(0);
    wait_cnt(11);
    wait_cnt(6);
    step();
    chk("valley6_up", int'(bus.count), 7);
    wait_cnt(16);
    chk("peak16_lamp", int'(bus.lamp), 'hFFFF);
    for (int k = 0; k < 40 && !bus.done; k++) step();
    chk("done_pulse", int'(bus.done), 1);
    chk("done_count", int'(bus.count), 0);
    repeat (5) step();
    chk("done_once", done_seen, 1);
    chk("end_bhv", int'(bus.led_bhv), int'(PASS));

    // Kickbacks in UP_HI and UP_TOP.
    do_reset();
    flick_pulse();
    wait_cnt(6);
    wait_cnt(0);
    wait_cnt(6);
    flick_pulse();
    chk("kick_hi6", int'(bus.count), 5);
    wait_cnt(0);
    step();
    chk("rise_after_kick", int'(bus.count), 1);
    wait_cnt(11);
    flick_pulse();
    chk("kick_hi11", int'(bus.count), 10);
    wait_cnt(6);
    step();
    chk("kick11_to_zero", int'(bus.count), 5);
    wait_cnt(0);
    wait_cnt(11);
    wait_cnt(6);
    wait_cnt(11);
    flick_pulse();
    chk("kick_top11", int'(bus.count), 10);
    wait_cnt(6);
    step();
    chk("kick_top11_up", int'(bus.count), 7);
    wait_cnt(16);
    flick_pulse();
    chk("kick_top16", int'(bus.count), 15);
    wait_cnt(6);
    step();
    chk("kick_top16_up", int'(bus.count), 7);
    wait_cnt(16);
    wait_cnt(0);
    step();

    // Flick held: loops 0..6..0 forever.
    do_reset();
    done_seen = 0;
    mx = 0;
    bus.flick = 1'b1;
    repeat (80) begin
      step();
      if (int'(bus.count) > mx) mx = int'(bus.count);
    end
    bus.flick = 1'b0;
    chk("held_max", mx, 6);
    chk("held_no_done", done_seen, 0);

    // Reset mid-sequence.
    do_reset();
    flick_pulse();
    wait_cnt(6);
    wait_cnt(0);
    wait_cnt(9);
    rst = 1'b1;
    step();
    chk("midrst_bhv", int'(bus.led_bhv), int'(PASS));
    rst = 1'b0;
    step();
    chk("post_rst_bhv", int'(bus.led_bhv), int'(PASS));
    repeat (10) step();
    chk("post_rst_count", int'(bus.count), 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
